// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: access sizes, FSM states,
// latency bounds and the request decode helpers.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned accesses, the reserved size code and addresses above the array all fault.
    function automatic logic req_fault(input logic [1:0] size, input logic [31:0] addr,
                                       input int unsigned addrW);
        logic f;
        f = 1'b0;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = addr[0];
            SZ_WORD: f = (addr[1:0] != 2'b00);
            default: f = 1'b1;
        endcase
        if ((addr >> addrW) != 32'd0) f = 1'b1;
        return f;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory controller.
interface data_memory_ctrl_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        WriteEn;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        RspValid;
    logic [31:0] ReadData;
    logic        Fault;

    modport master (
        output ReqValid, WriteEn, Size, Unsigned, Address, WriteData,
        input  ReqReady, RspValid, ReadData, Fault
    );

    modport slave (
        input  ReqValid, WriteEn, Size, Unsigned, Address, WriteData,
        output ReqReady, RspValid, ReadData, Fault
    );

endinterface

// File: rtl/dm_align.sv
// Little-endian lane handling: store data placement with byte enables, and
// load lane extraction with sign/zero extension.
module dm_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wrData,
    input  logic [31:0] i_rdWord,
    output logic [31:0] o_wrWord,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signBit;

    // Replicating the store data across lanes lets the byte enables alone pick the destination.
    always_comb begin
        o_wrWord = i_wrData;
        case (i_size)
            SZ_BYTE: o_wrWord = {4{i_wrData[7:0]}};
            SZ_HALF: o_wrWord = {2{i_wrData[15:0]}};
            default: o_wrWord = i_wrData;
        endcase
        o_byteEn = byte_en(i_size, i_lane);
    end

    always_comb begin
        w_byte     = i_rdWord[{i_lane, 3'b000} +: 8];
        w_half     = i_lane[1] ? i_rdWord[31:16] : i_rdWord[15:0];
        w_signBit  = 1'b0;
        o_loadData = 32'd0;
        case (i_size)
            SZ_BYTE: begin
                w_signBit  = ~i_unsigned & w_byte[7];
                o_loadData = {{24{w_signBit}}, w_byte};
            end
            SZ_HALF: begin
                w_signBit  = ~i_unsigned & w_half[15];
                o_loadData = {{16{w_signBit}}, w_half};
            end
            SZ_WORD: o_loadData = i_rdWord;
            default: o_loadData = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with a fixed-latency request/response handshake,
// byte/half/word access and fault detection.
module data_memory_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    data_memory_ctrl_if.slave bus
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int CNT_W = $clog2(LATENCY_MAX);

    state_e             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_rspData;
    logic               r_rspFault;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept;
    logic               w_fault;
    logic               w_write;
    logic [ADDR_W-3:0]  w_wordIdx;
    logic [31:0]        w_rdWord;
    logic [31:0]        w_wrWord;
    logic [3:0]         w_byteEn;
    logic [31:0]        w_loadData;
    logic               w_rspValid;

    assign bus.ReqReady = !Reset && (r_state != ST_WAIT);
    assign w_accept     = bus.ReqValid && bus.ReqReady;
    assign w_fault      = req_fault(bus.Size, bus.Address, ADDR_W);
    assign w_write      = w_accept && bus.WriteEn && !w_fault;
    assign w_wordIdx    = bus.Address[ADDR_W-1:2];
    assign w_rdWord     = r_mem[w_wordIdx];

    dm_align u_align (
        .i_size     (bus.Size),
        .i_unsigned (bus.Unsigned),
        .i_lane     (bus.Address[1:0]),
        .i_wrData   (bus.WriteData),
        .i_rdWord   (w_rdWord),
        .o_wrWord   (w_wrWord),
        .o_byteEn   (w_byteEn),
        .o_loadData (w_loadData)
    );

    // Memory has no reset; stores commit at the accept edge so a following load sees them.
    always_ff @(posedge Clock) begin
        if (w_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byteEn[i]) r_mem[w_wordIdx][8*i +: 8] <= w_wrWord[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_rspData  <= 32'd0;
            r_rspFault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        r_state    <= (LATENCY > 1) ? ST_WAIT : ST_RESP;
                        r_count    <= CNT_W'(LATENCY - 1);
                        r_rspData  <= (bus.WriteEn || w_fault) ? 32'd0 : w_loadData;
                        r_rspFault <= w_fault;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_count == CNT_W'(1)) begin
                        r_state <= ST_RESP;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_rspValid   = (r_state == ST_RESP);
    assign bus.RspValid = w_rspValid;
    assign bus.ReadData = w_rspValid ? r_rspData : 32'd0;
    assign bus.Fault    = w_rspValid && r_rspFault;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: latency-2 controller for data/fault/reset behaviour and a
// latency-1 controller for back-to-back streaming.
module tb_data_memory_ctrl;
    import data_mem_pkg::*;

    logic Clock;
    logic Reset;
    int   errors;
    int   checks;

    data_memory_ctrl_if busA ();
    data_memory_ctrl_if busB ();

    data_memory_ctrl #(.ADDR_W(10), .LATENCY(2)) dutA (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (busA)
    );

    data_memory_ctrl #(.ADDR_W(10), .LATENCY(1)) dutB (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (busB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
        busA.ReqValid  = 1'b1;
        busA.WriteEn   = we;
        busA.Size      = sz;
        busA.Unsigned  = uns;
        busA.Address   = addr;
        busA.WriteData = wd;
    endtask

    // Full latency-2 transaction on busA, starting and ending 1 time unit after a rising edge.
    task automatic doTransaction(input string tag, input logic we, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] expData, input logic expFault);
        applyStimulus(we, sz, uns, addr, wd);
        checkOutput({tag, "/ready"}, {31'd0, busA.ReqReady}, 32'd1);
        @(posedge Clock); #1;
        busA.ReqValid = 1'b0;
        checkOutput({tag, "/waitValid"}, {31'd0, busA.RspValid}, 32'd0);
        checkOutput({tag, "/waitReady"}, {31'd0, busA.ReqReady}, 32'd0);
        @(posedge Clock); #1;
        checkOutput({tag, "/rspValid"}, {31'd0, busA.RspValid}, 32'd1);
        checkOutput({tag, "/data"}, busA.ReadData, expData);
        checkOutput({tag, "/fault"}, {31'd0, busA.Fault}, {31'd0, expFault});
        @(posedge Clock); #1;
        checkOutput({tag, "/idleValid"}, {31'd0, busA.RspValid}, 32'd0);
        checkOutput({tag, "/idleData"}, busA.ReadData, 32'd0);
        checkOutput({tag, "/idleFault"}, {31'd0, busA.Fault}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b1;
        busA.ReqValid = 1'b0; busA.WriteEn = 1'b0; busA.Size = SZ_WORD;
        busA.Unsigned = 1'b0; busA.Address = 32'd0; busA.WriteData = 32'd0;
        busB.ReqValid = 1'b0; busB.WriteEn = 1'b0; busB.Size = SZ_WORD;
        busB.Unsigned = 1'b0; busB.Address = 32'd0; busB.WriteData = 32'd0;

        repeat (2) @(posedge Clock);
        #1;
        checkOutput("rst/readyA", {31'd0, busA.ReqReady}, 32'd0);
        checkOutput("rst/readyB", {31'd0, busB.ReqReady}, 32'd0);
        checkOutput("rst/valid", {31'd0, busA.RspValid}, 32'd0);
        checkOutput("rst/data", busA.ReadData, 32'd0);
        checkOutput("rst/fault", {31'd0, busA.Fault}, 32'd0);
        Reset = 1'b0;
        #1;
        checkOutput("rel/readyA", {31'd0, busA.ReqReady}, 32'd1);
        checkOutput("rel/readyB", {31'd0, busB.ReqReady}, 32'd1);
        @(posedge Clock); #1;

        $display("[TB] latency-2 data path");
        doTransaction("stW",   1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        doTransaction("ldW",   1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        doTransaction("ldBs",  1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
        doTransaction("ldBu",  1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        doTransaction("ldHs",  1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
        doTransaction("ldHu",  1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
        doTransaction("stB",   1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hAAAAAA55, 32'h0,        1'b0);
        doTransaction("ldW2",  1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0);
        doTransaction("ldB0s", 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);

        $display("[TB] fault cases");
        doTransaction("fLdW12", 1'b0, SZ_WORD, 1'b0, 32'h12,  32'h0,        32'h0, 1'b1);
        doTransaction("fStH11", 1'b1, SZ_HALF, 1'b0, 32'h11,  32'h00001234, 32'h0, 1'b1);
        doTransaction("fLdW400",1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0,        32'h0, 1'b1);
        doTransaction("fStW410",1'b1, SZ_WORD, 1'b0, 32'h410, 32'h00000000, 32'h0, 1'b1);
        doTransaction("fSz11",  1'b0, 2'b11,   1'b0, 32'h10,  32'h0,        32'h0, 1'b1);
        doTransaction("ldAfterF",1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        $display("[TB] read after write");
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678);
        @(posedge Clock); #1;
        busA.ReqValid = 1'b0;
        @(posedge Clock); #1;
        checkOutput("raw/stRsp", {31'd0, busA.RspValid}, 32'd1);
        checkOutput("raw/readyInResp", {31'd0, busA.ReqReady}, 32'd1);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        @(posedge Clock); #1;
        busA.ReqValid = 1'b0;
        checkOutput("raw/wait", {31'd0, busA.RspValid}, 32'd0);
        @(posedge Clock); #1;
        checkOutput("raw/ldRsp", {31'd0, busA.RspValid}, 32'd1);
        checkOutput("raw/ldData", busA.ReadData, 32'h12345678);
        @(posedge Clock); #1;

        $display("[TB] reset during wait");
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        @(posedge Clock); #1;
        busA.ReqValid = 1'b0;
        Reset = 1'b1;
        #1;
        checkOutput("rstW/ready", {31'd0, busA.ReqReady}, 32'd0);
        checkOutput("rstW/valid", {31'd0, busA.RspValid}, 32'd0);
        @(posedge Clock); #1;
        checkOutput("rstW/validHeld", {31'd0, busA.RspValid}, 32'd0);
        Reset = 1'b0;
        #1;
        checkOutput("rstW/readyRel", {31'd0, busA.ReqReady}, 32'd1);
        @(posedge Clock); #1;
        checkOutput("rstW/noRsp", {31'd0, busA.RspValid}, 32'd0);
        doTransaction("rstW/ld", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        $display("[TB] latency-1 streaming");
        for (int k = 0; k < 8; k++) begin
            logic [31:0] val;
            val = 32'h11111111 * 32'((k % 4) + 1);
            busB.ReqValid  = 1'b1;
            busB.WriteEn   = (k < 4);
            busB.Size      = SZ_WORD;
            busB.Unsigned  = 1'b0;
            busB.Address   = 32'(4 * (k % 4));
            busB.WriteData = (k < 4) ? val : 32'h0;
            @(posedge Clock); #1;
            checkOutput($sformatf("strm%0d/valid", k), {31'd0, busB.RspValid}, 32'd1);
            checkOutput($sformatf("strm%0d/ready", k), {31'd0, busB.ReqReady}, 32'd1);
            checkOutput($sformatf("strm%0d/data", k), busB.ReadData, (k < 4) ? 32'h0 : val);
            checkOutput($sformatf("strm%0d/fault", k), {31'd0, busB.Fault}, 32'd0);
        end
        busB.ReqValid = 1'b0;
        @(posedge Clock); #1;
        checkOutput("strm/end", {31'd0, busB.RspValid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10: byte-address bits decoded; DEPTH = 2**(ADDR_W-2) 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..4: cycles from request accept edge to response.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports are Clock and Reset.
REQ-004 Port Clock, input, 1: all state updates on rising edge.
REQ-005 Port Reset, input, 1: asynchronous, active-high clear.
REQ-006 Port ReqValid, input, 1: request present.
REQ-007 Port ReqReady, output, 1: block can accept a request this cycle.
REQ-008 Port WriteEn, input, 1: 1 = store, 0 = load.
REQ-009 Port Size, input, 2: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 Port Unsigned, input, 1: loads zero-extend when 1, sign-extend when 0.
REQ-011 Port Address, input, 32: byte address.
REQ-012 Port WriteData, input, 32: store data, right-justified.
REQ-013 Port RspValid, output, 1: one-cycle response pulse.
REQ-014 Port ReadData, output, 32: extended load data; valid only with RspValid.
REQ-015 Port Fault, output, 1: request was faulted; valid only with RspValid.

Function
REQ-016 Accept: the block SHALL accept a request on a rising edge with ReqValid=1 and ReqReady=1; all request inputs are sampled at that edge only.
REQ-017 FSM: the block SHALL implement states IDLE, WAIT and RESP.
- IDLE: ReqReady=1; on accept go to WAIT if LATENCY>1, else RESP.
- WAIT: ReqReady=0; down-counter loaded with LATENCY-1 at accept; go to RESP when it reaches 1.
- RESP: RspValid=1 and ReqReady=1; accept goes to WAIT/RESP as from IDLE; otherwise go to IDLE.
REQ-018 Timing: RspValid SHALL be high exactly in the cycle following the LATENCY-th rising edge after accept, giving one response per request with no overlap.
REQ-019 Byte order: the block SHALL be little-endian; the byte lane is Address[1:0] and the halfword lane is Address[1].
REQ-020 Stores SHALL write only the enabled byte lanes of word Address[ADDR_W-1:2] at the accept edge; other lanes are unchanged. The response carries ReadData=0.
REQ-021 Loads SHALL read the word at the accept edge, extract the lane, extend to 32 bits per Unsigned, and hold the result until response. Unsigned is ignored for word loads.
REQ-022 Fault SHALL be set when any of the following holds: half with Address[0]=1; word with Address[1:0]!=0; Size=11; Address[31:ADDR_W]!=0.
REQ-023 A faulted request SHALL NOT modify memory, SHALL return ReadData=0 and Fault=1, and SHALL keep the same latency.
REQ-024 Read-after-write: a load accepted in the RESP cycle of a store to the same word SHALL return the new data.
REQ-025 When RspValid=0, ReadData and Fault SHALL be 0.

Reset
REQ-026 Reset SHALL force state IDLE, counter 0, RspValid=0, ReadData=0 and Fault=0.
REQ-027 ReqReady SHALL be 0 while Reset=1 and 1 in the first cycle after release.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset during WAIT/RESP SHALL drop the pending response; a store accepted before reset remains committed.

Structure
REQ-030 Shared package data_mem_pkg SHALL hold: the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD); the FSM state enum; LATENCY bounds; and the fault-check and byte-enable functions.
REQ-031 A sub-module dm_align SHALL contain all store lane placement/byte-enable generation and load extraction/extension; it is combinational, and the FSM and array stay in data_memory_ctrl.

Verification
REQ-032 LATENCY=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> RspValid pulses 2 cycles after each accept; ReadData=0xDEADBEEF, Fault=0.
REQ-033 After REQ-032: load byte @0x13 signed -> 0xFFFFFFDE; load byte @0x13 unsigned -> 0x000000DE; load half @0x10 signed -> 0xFFFFBEEF.
REQ-034 After REQ-032: store byte 0x55 @0x11, then load word @0x10 -> 0xDEAD55EF.
REQ-035 Fault cases, each -> Fault=1, ReadData=0, memory unchanged, response at normal latency:
- load word @0x12;
- store half @0x11;
- load word @0x400 with ADDR_W=10.
REQ-036 ReqValid held high continuously, LATENCY=1 -> one accept per cycle; RspValid high every cycle after the first edge; ReqReady never 0.
REQ-037 Reset asserted in WAIT after a load accept -> no RspValid; ReqReady=1 after release; the next load responds normally.
